// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath select codes and the control word carried to the datapath.
package mips_ctrl_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_R_EXEC,
    S_R_WB,
    S_BRANCH,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_LUI_WB,
    S_JUMP,
    S_EXC
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR} aluop_t;
  typedef enum logic [1:0] {PCS_ALU, PCS_ALUOUT, PCS_JUMP, PCS_EXC} pcsrc_t;
  typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_LUI, M2R_RSVD} memtoreg_t;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_TIMEOUT, CAUSE_RSVD} cause_t;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] REGDST_RT    = 2'd0;
  localparam logic [1:0] REGDST_RD    = 2'd1;

  typedef struct packed {
    logic      pcwrite;
    logic      pcwritecond;
    logic      pcwritecondne;
    logic      iord;
    logic      memread;
    logic      memwrite;
    logic      irwrite;
    logic      mdrwrite;
    logic      awrite;
    logic      bwrite;
    logic      aluoutwrite;
    logic      regwrite;
    logic      alusrca;
    logic      epcwrite;
    logic [1:0] regdst;
    memtoreg_t memtoreg;
    logic [1:0] alusrcb;
    pcsrc_t    pcsource;
    aluop_t    aluop;
  } ctrl_t;

  // Instruction class selected in DECODE; anything unlisted is illegal.
  function automatic state_t decode_op(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE:      return S_R_EXEC;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_LW, OP_SW:  return S_MEM_ADDR;
      OP_ADDI:       return S_ADDI_EXEC;
      OP_LUI:        return S_LUI_WB;
      OP_J:          return S_JUMP;
      default:       return S_EXC;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Opcode/handshake inputs and control word outputs between control unit and datapath.
interface mc_control_unit_if import mips_ctrl_pkg::*; #(
  parameter int unsigned ALUOP_W = 3
);
  logic [OP_W-1:0]    Op;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               PCWriteCondNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MDRWrite;
  logic               AWrite;
  logic               BWrite;
  logic               ALUOutWrite;
  logic               RegWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         PCSource;
  logic               EPCWrite;
  logic [1:0]         Cause;

  modport master (
    input  Op, MemReady,
    output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, MDRWrite, AWrite, BWrite, ALUOutWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite, Cause
  );

  modport slave (
    output Op, MemReady,
    input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, MDRWrite, AWrite, BWrite, ALUOutWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite, Cause
  );
endinterface

// File: rtl/mc_control_unit_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a bus timeout.
module mem_wait_timer import mips_ctrl_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic ready,
  output logic timeout
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!ready) begin
      count <= count + CNT_W'(1);
    end
  end

  // A ready arriving on the limit cycle still wins over the timeout.
  assign timeout = (count == CNT_W'(MEM_TIMEOUT)) && !ready;

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: decodes state into datapath strobes and
// raises illegal-opcode and memory-timeout exceptions.
module mc_control_unit import mips_ctrl_pkg::*; #(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic               Clk,
  input logic               Reset,
  mc_control_unit_if.master bus
);

  state_t state_q, state_d;
  cause_t cause_q, cause_d;
  logic   br_ne_q, br_ne_d;
  logic   timeout;
  ctrl_t  ctrl, ctrl_o;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (state_d != state_q),
    .ready   (bus.MemReady),
    .timeout (timeout)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      br_ne_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      br_ne_q <= br_ne_d;
    end
  end

  // Next state and control word; branch polarity is latched in DECODE so Op may change afterwards.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    br_ne_d = br_ne_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        if (timeout) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          ctrl.memread = 1'b1;
          if (bus.MemReady) begin
            ctrl.irwrite = 1'b1;
            ctrl.pcwrite = 1'b1;
            state_d      = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        ctrl.awrite      = 1'b1;
        ctrl.bwrite      = 1'b1;
        ctrl.aluoutwrite = 1'b1;
        ctrl.alusrcb     = SRCB_IMM_SH2;
        state_d          = decode_op(bus.Op);
        br_ne_d          = (bus.Op == OP_BNE);
        if (state_d == S_EXC) cause_d = CAUSE_ILLEGAL;
      end
      S_R_EXEC: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALU_FUNCT;
        ctrl.aluoutwrite = 1'b1;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = REGDST_RD;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alusrca       = 1'b1;
        ctrl.aluop         = ALU_SUB;
        ctrl.pcsource      = PCS_ALUOUT;
        ctrl.pcwritecond   = !br_ne_q;
        ctrl.pcwritecondne = br_ne_q;
        state_d            = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_IMM;
        ctrl.aluoutwrite = 1'b1;
        state_d          = (bus.Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (timeout) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          ctrl.iord    = 1'b1;
          ctrl.memread = 1'b1;
          if (bus.MemReady) begin
            ctrl.mdrwrite = 1'b1;
            state_d       = S_MEM_WB;
          end
        end
      end
      S_MEM_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = M2R_MDR;
        state_d       = S_FETCH;
      end
      S_MEM_WR: begin
        if (timeout) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          ctrl.iord     = 1'b1;
          ctrl.memwrite = 1'b1;
          if (bus.MemReady) state_d = S_FETCH;
        end
      end
      S_ADDI_EXEC: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_IMM;
        ctrl.aluoutwrite = 1'b1;
        state_d          = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_LUI_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = M2R_LUI;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCS_JUMP;
        state_d       = S_FETCH;
      end
      S_EXC: begin
        ctrl.epcwrite = 1'b1;
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCS_EXC;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every strobe low regardless of the decoded state.
  assign ctrl_o = Reset ? ctrl : '0;

  assign bus.PCWrite       = ctrl_o.pcwrite;
  assign bus.PCWriteCond   = ctrl_o.pcwritecond;
  assign bus.PCWriteCondNe = ctrl_o.pcwritecondne;
  assign bus.IorD          = ctrl_o.iord;
  assign bus.MemRead       = ctrl_o.memread;
  assign bus.MemWrite      = ctrl_o.memwrite;
  assign bus.IRWrite       = ctrl_o.irwrite;
  assign bus.MDRWrite      = ctrl_o.mdrwrite;
  assign bus.AWrite        = ctrl_o.awrite;
  assign bus.BWrite        = ctrl_o.bwrite;
  assign bus.ALUOutWrite   = ctrl_o.aluoutwrite;
  assign bus.RegWrite      = ctrl_o.regwrite;
  assign bus.RegDst        = ctrl_o.regdst;
  assign bus.MemtoReg      = ctrl_o.memtoreg;
  assign bus.ALUSrcA       = ctrl_o.alusrca;
  assign bus.ALUSrcB       = ctrl_o.alusrcb;
  assign bus.ALUOp         = ALUOP_W'(ctrl_o.aluop);
  assign bus.PCSource      = ctrl_o.pcsource;
  assign bus.EPCWrite      = ctrl_o.epcwrite;
  assign bus.Cause         = cause_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: expected per-cycle control words are planned
// from instruction-level rules, then replayed against the design.
module tb_mc_control_unit;

  localparam int unsigned TMO = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mc_control_unit_if #(.ALUOP_W(3)) bus();
  mc_control_unit #(.ALUOP_W(3), .MEM_TIMEOUT(TMO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic pcw, pcwc, pcwcne, iord, mrd, mwr, irw, mdrw, aw, bw, aow, rw, srca, epcw;
    logic [1:0] regdst, m2r, srcb, pcsrc;
    logic [2:0] aluop;
    logic [1:0] cause;
  } exp_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
    exp_t       e;
  } step_t;

  step_t      plan_q[$];
  logic [1:0] m_cause;
  int         checks = 0;
  int         errors = 0;

  function automatic exp_t base();
    exp_t e = '0;
    e.cause = m_cause;
    return e;
  endfunction

  function automatic exp_t exc_rec();
    exp_t e = base();
    e.epcw = 1'b1; e.pcw = 1'b1; e.pcsrc = 2'd3;
    return e;
  endfunction

  function automatic void push(input logic rdy, input logic [5:0] op, input exp_t e);
    step_t s;
    s.rdy = rdy; s.op = op; s.e = e;
    plan_q.push_back(s);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  // kind 0 fetch, 1 load, 2 store; lat = not-ready cycles before MemReady. Returns 1 on timeout.
  function automatic bit plan_mem(input int kind, input int lat);
    exp_t e;
    for (int k = 0; k <= int'(TMO); k++) begin
      e = base();
      if (k == lat) begin
        case (kind)
          0:       begin e.mrd = 1'b1; e.srcb = 2'd1; e.irw = 1'b1; e.pcw = 1'b1; end
          1:       begin e.iord = 1'b1; e.mrd = 1'b1; e.mdrw = 1'b1; end
          default: begin e.iord = 1'b1; e.mwr = 1'b1; end
        endcase
        push(1'b1, rnd_op(), e);
        return 1'b0;
      end
      if (k == int'(TMO)) begin
        if (kind == 0) e.srcb = 2'd1;
        push(1'b0, rnd_op(), e);
        m_cause = 2'd2;
        push(rnd_bit(), rnd_op(), exc_rec());
        return 1'b1;
      end
      case (kind)
        0:       begin e.mrd = 1'b1; e.srcb = 2'd1; end
        1:       begin e.iord = 1'b1; e.mrd = 1'b1; end
        default: begin e.iord = 1'b1; e.mwr = 1'b1; end
      endcase
      push(1'b0, rnd_op(), e);
    end
    return 1'b1;
  endfunction

  // One whole instruction; mop is the Op presented during address calculation.
  function automatic void plan_instr(input logic [5:0] op, input int f_lat,
                                     input int m_lat, input logic [5:0] mop);
    exp_t e;
    if (plan_mem(0, f_lat)) return;
    e = base(); e.aw = 1'b1; e.bw = 1'b1; e.aow = 1'b1; e.srcb = 2'd3;
    push(rnd_bit(), op, e);
    e = base();
    case (op)
      6'h00: begin
        e.srca = 1'b1; e.aluop = 3'd2; e.aow = 1'b1; push(rnd_bit(), rnd_op(), e);
        e = base(); e.rw = 1'b1; e.regdst = 2'd1; push(rnd_bit(), rnd_op(), e);
      end
      6'h04, 6'h05: begin
        e.srca = 1'b1; e.aluop = 3'd1; e.pcsrc = 2'd1;
        e.pcwc = (op == 6'h04); e.pcwcne = (op == 6'h05);
        push(rnd_bit(), rnd_op(), e);
      end
      6'h23, 6'h2B: begin
        e.srca = 1'b1; e.srcb = 2'd2; e.aow = 1'b1; push(rnd_bit(), mop, e);
        if (mop == 6'h2B) void'(plan_mem(2, m_lat));
        else if (!plan_mem(1, m_lat)) begin
          e = base(); e.rw = 1'b1; e.m2r = 2'd1; push(rnd_bit(), rnd_op(), e);
        end
      end
      6'h08: begin
        e.srca = 1'b1; e.srcb = 2'd2; e.aow = 1'b1; push(rnd_bit(), rnd_op(), e);
        e = base(); e.rw = 1'b1; push(rnd_bit(), rnd_op(), e);
      end
      6'h0F: begin
        e.rw = 1'b1; e.m2r = 2'd2; push(rnd_bit(), rnd_op(), e);
      end
      6'h02: begin
        e.pcw = 1'b1; e.pcsrc = 2'd2; push(rnd_bit(), rnd_op(), e);
      end
      default: begin
        m_cause = 2'd1;
        push(rnd_bit(), rnd_op(), exc_rec());
      end
    endcase
  endfunction

  function automatic exp_t sample();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNe, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MDRWrite, bus.AWrite, bus.BWrite,
            bus.ALUOutWrite, bus.RegWrite, bus.ALUSrcA, bus.EPCWrite, bus.RegDst,
            bus.MemtoReg, bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.Cause};
  endfunction

  task automatic drive(input step_t s, output exp_t act);
    @(negedge Clk);
    Reset        = 1'b1;
    bus.MemReady = s.rdy;
    bus.Op       = s.op;
    #1;
    act = sample();
  endtask

  task automatic test_reset();
    exp_t act;
    Reset = 1'b0; bus.MemReady = 1'b1; bus.Op = 6'h00; m_cause = 2'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk); #1;
      act = sample();
      checks++;
      if (act !== exp_t'(0)) begin
        errors++; $display("FAIL reset cycle %0d: got %h expected %h", i, act, exp_t'(0));
      end
    end
  endtask

  task automatic test_rtype();
    exp_t act; step_t s;
    plan_instr(6'h00, 0, 0, 6'h00);
    plan_instr(6'h02, 0, 0, 6'h00);
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL rtype: got %h expected %h", act, s.e); end
    end
  endtask

  task automatic test_load_wait();
    exp_t act; step_t s;
    plan_instr(6'h23, 2, 3, 6'h23);
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL load_wait: got %h expected %h", act, s.e); end
    end
  endtask

  task automatic test_branch();
    exp_t act; step_t s;
    plan_instr(6'h05, 0, 0, 6'h00);
    plan_instr(6'h04, 1, 0, 6'h00);
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL branch: got %h expected %h", act, s.e); end
    end
  endtask

  task automatic test_illegal();
    exp_t act; step_t s;
    plan_instr(6'h3F, 0, 0, 6'h00);
    plan_instr(6'h0F, 0, 0, 6'h00);
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL illegal: got %h expected %h", act, s.e); end
    end
  endtask

  task automatic test_store_timeout();
    exp_t act; step_t s;
    plan_instr(6'h2B, 0, 100, 6'h2B);
    plan_instr(6'h2B, 0, int'(TMO) - 1, 6'h2B);
    plan_instr(6'h2B, 0, int'(TMO), 6'h2B);
    plan_instr(6'h23, 0, int'(TMO) + 1, 6'h23);
    plan_instr(6'h08, int'(TMO) + 1, 0, 6'h00);
    plan_instr(6'h08, int'(TMO), 0, 6'h00);
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL timeout: got %h expected %h", act, s.e); end
    end
  endtask

  task automatic test_mid_reset();
    exp_t act; step_t s;
    plan_instr(6'h3F, 0, 0, 6'h00);
    plan_instr(6'h2B, 0, 100, 6'h2B);
    // stop after fetch, decode, address and two write-wait cycles of the store
    while (plan_q.size() > int'(TMO) + 2 - 2) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL mid_reset pre: got %h expected %h", act, s.e); end
    end
    plan_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    act = sample();
    checks++;
    if (act.mwr !== 1'b0 || act.cause !== 2'd1) begin
      errors++; $display("FAIL mid_reset hold: got MemWrite=%b Cause=%0d expected MemWrite=0 Cause=1", act.mwr, act.cause);
    end
    @(negedge Clk); #1;
    act = sample();
    checks++;
    if (act !== exp_t'(0)) begin
      errors++; $display("FAIL mid_reset after: got %h expected %h", act, exp_t'(0));
    end
    m_cause = 2'd0;
    plan_instr(6'h00, 0, 0, 6'h00);
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front(); drive(s, act); checks++;
      if (act !== s.e) begin errors++; $display("FAIL mid_reset post: got %h expected %h", act, s.e); end
    end
  endtask

  task automatic test_random();
    exp_t act; step_t s;
    logic [5:0] legal [8] = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h08, 6'h0F, 6'h02};
    logic [5:0] op, mop;
    int f_lat;
    for (int n = 0; n < 150; n++) begin
      op    = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)] : rnd_op();
      mop   = ($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B;
      f_lat = ($urandom_range(0, 9) == 0) ? int'(TMO) + 1 : int'($urandom_range(0, 2));
      plan_instr(op, f_lat, int'($urandom_range(0, 6)), mop);
      while (plan_q.size() > 0) begin
        s = plan_q.pop_front(); drive(s, act); checks++;
        if (act !== s.e) begin
          errors++; $display("FAIL random instr %0d op %h: got %h expected %h", n, op, act, s.e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_store_timeout();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALUOP_W, default 3, width of the ALUOp output.
REQ-002 Parameter MEM_TIMEOUT, default 15, max wait cycles for MemReady before a bus-error exception; legal range 1..255.
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 Op  in  6  opcode field from the instruction register.
REQ-006 MemReady  in  1  memory completes the current access this cycle.
REQ-007 PCWrite, PCWriteCond, PCWriteCondNe  out  1 each  unconditional PC load; PC load if Zero; PC load if not Zero.
REQ-008 IorD, MemRead, MemWrite, IRWrite, MDRWrite  out  1 each  memory address select, read strobe, write strobe, IR load, MDR load.
REQ-009 AWrite, BWrite, ALUOutWrite  out  1 each  A, B and ALUOut register loads.
REQ-010 RegWrite  out  1; RegDst  out  2 (0 rt, 1 rd); MemtoReg  out  2 (0 ALUOut, 1 MDR, 2 imm<<16).
REQ-011 ALUSrcA  out  1 (0 PC, 1 A); ALUSrcB  out  2 (0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2).
REQ-012 ALUOp  out  ALUOP_W (0 add, 1 sub, 2 funct-decoded, 3 or); PCSource  out  2 (0 ALU result, 1 ALUOut, 2 jump target, 3 exception vector).
REQ-013 EPCWrite  out  1; Cause  out  2 (0 none, 1 illegal opcode, 2 bus timeout), registered.

Function
REQ-014 States: FETCH, DECODE, R_EXEC, R_WB, BRANCH, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ADDI_EXEC, ADDI_WB, LUI_WB, JUMP, EXC.
REQ-015 Every output not explicitly asserted in a state SHALL be 0 in that state; outputs are a pure decode of state, MemReady and the wait counter.
REQ-016 FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0; IRWrite=1 and PCWrite=1 only in the cycle MemReady=1, then go to DECODE; otherwise stay.
REQ-017 DECODE: AWrite=BWrite=ALUOutWrite=1, ALUSrcA=0, ALUSrcB=3, ALUOp=0; next state by Op: 0x00 R_EXEC, 0x04/0x05 BRANCH, 0x23/0x2B MEM_ADDR, 0x08 ADDI_EXEC, 0x0F LUI_WB, 0x02 JUMP, any other EXC with Cause=1.
REQ-018 R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2, ALUOutWrite=1 -> R_WB; R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1; PCWriteCond=1 for Op 0x04, PCWriteCondNe=1 for Op 0x05 -> FETCH.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0, ALUOutWrite=1 -> MEM_RD (Op 0x23) or MEM_WR (Op 0x2B).
REQ-021 MEM_RD: IorD=1, MemRead=1, MDRWrite=1 in the MemReady cycle -> MEM_WB; MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
REQ-022 MEM_WR: IorD=1, MemWrite=1 held until MemReady=1 -> FETCH.
REQ-023 ADDI_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=0, ALUOutWrite=1 -> ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
REQ-024 LUI_WB: RegWrite=1, RegDst=0, MemtoReg=2 -> FETCH; JUMP: PCWrite=1, PCSource=2 -> FETCH.
REQ-025 8-bit wait counter clears on entry to FETCH, MEM_RD or MEM_WR, increments each cycle MemReady=0 in those states; when it equals MEM_TIMEOUT with MemReady=0, go to EXC with Cause=2, deasserting all memory strobes.
REQ-026 MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT: access completes normally, no exception.
REQ-027 EXC: EPCWrite=1, PCWrite=1, PCSource=3 for one cycle -> FETCH; Cause holds its value until the next exception or reset.
REQ-028 Op is sampled only in DECODE and MEM_ADDR; changes elsewhere SHALL have no effect.

Reset
REQ-029 Reset=0 at a rising edge: state=FETCH, wait counter=0, Cause=0, regardless of current state or pending memory access.
REQ-030 While Reset=0 all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite, EPCWrite) SHALL be 0; normal FETCH begins on the first edge with Reset=1.

Structure
REQ-031 State enum, opcode constants, ALUOp/PCSource/MemtoReg/Cause encodings SHALL live in shared package mips_ctrl_pkg.
REQ-032 Wait counter/timeout logic SHALL be sub-module mem_wait_timer (inputs Clk, Reset, clear, ready; output timeout).

Verification
REQ-033 Op=0x00, MemReady always 1 -> FETCH, DECODE, R_EXEC, R_WB; RegWrite=1, RegDst=1 in cycle 4; back in FETCH cycle 5.
REQ-034 Op=0x23, MemReady low 3 cycles in MEM_RD -> MemRead/IorD held 4 cycles, MDRWrite=1 only in 4th, then MEM_WB with MemtoReg=1.
REQ-035 Op=0x05 -> BRANCH with PCWriteCondNe=1, PCWriteCond=0, ALUOp=1, PCSource=1.
REQ-036 Op=0x3F -> EXC after DECODE; EPCWrite=1, PCSource=3, Cause=1; next cycle FETCH.
REQ-037 MEM_TIMEOUT=4, MemReady stuck 0 in MEM_WR -> MemWrite high 4 cycles, then EXC, Cause=2; repeat with MemReady=1 on 4th cycle -> FETCH, Cause unchanged.
REQ-038 Reset=0 asserted mid-MEM_WR -> next edge state=FETCH, MemWrite=0, Cause=0.
